// File: rtl/pacman_motion.sv
// Per-frame Pac-Man position controller: probes the wall lookup once or twice per
// frame, then turns, continues or stops, with a horizontal tunnel wrap.
module pacman_motion #(
  parameter logic [9:0] START_X = 10'd208,
  parameter logic [9:0] START_Y = 10'd320,
  parameter int         STEP    = 1,
  parameter logic [9:0] MAX_X   = 10'd432
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       isWall,
  output logic [9:0] probe_x,
  output logic [9:0] probe_y,
  output logic [9:0] PacX,
  output logic [9:0] PacY,
  output logic [1:0] dir,
  output logic       moving,
  output logic [1:0] fsm_state
);

  localparam logic [9:0] STEP_PX = 10'(STEP);

  typedef enum logic [1:0] {IDLE, PROBE_REQ, PROBE_CUR, MOVE} state_t;

  state_t     state, state_nxt;
  logic       sync1, sync2, edge_q, frame_tick;
  logic [1:0] req_dir;
  logic       key_valid;
  logic [1:0] key_dir;
  logic       aligned;
  logic       go;

  assign fsm_state = state;

  // frame_clk is asynchronous: two-flop synchronizer, then rising-edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= frame_clk;
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  assign frame_tick = sync2 & ~edge_q;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = 2'd0;
    case (keycode)
      8'h1A:   key_dir = 2'd0;
      8'h04:   key_dir = 2'd1;
      8'h16:   key_dir = 2'd2;
      8'h07:   key_dir = 2'd3;
      default: key_valid = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) req_dir <= 2'd1;
    else if (key_valid) req_dir <= key_dir;
  end

  assign aligned = (PacX[3:0] == 4'd0) && (PacY[3:0] == 4'd0);

  // Pixel just beyond the sprite edge in direction d; 10-bit wrap is intentional
  function automatic logic [19:0] probe_point(input logic [1:0] d,
                                              input logic [9:0] x,
                                              input logic [9:0] y);
    case (d)
      2'd0:    probe_point = {x, y - 10'd1};
      2'd1:    probe_point = {x - 10'd1, y};
      2'd2:    probe_point = {x, y + 10'd16};
      default: probe_point = {x + 10'd16, y};
    endcase
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (frame_tick) state_nxt = (aligned && (req_dir != dir)) ? PROBE_REQ : PROBE_CUR;
      end
      PROBE_REQ: state_nxt = isWall ? PROBE_CUR : MOVE;
      PROBE_CUR: state_nxt = MOVE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    {probe_x, probe_y} = 20'd0;
    case (state)
      PROBE_REQ: {probe_x, probe_y} = probe_point(req_dir, PacX, PacY);
      PROBE_CUR: {probe_x, probe_y} = probe_point(dir, PacX, PacY);
      default:   {probe_x, probe_y} = 20'd0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PacX   <= START_X;
      PacY   <= START_Y;
      dir    <= 2'd1;
      moving <= 1'b0;
      go     <= 1'b0;
    end else begin
      case (state)
        PROBE_REQ: begin
          if (!isWall) begin
            dir <= req_dir;
            go  <= 1'b1;
          end
        end
        PROBE_CUR: go <= ~isWall;
        MOVE: begin
          moving <= go;
          if (go) begin
            case (dir)
              2'd0:    PacY <= PacY - STEP_PX;
              2'd1:    PacX <= (PacX == 10'd0) ? MAX_X : PacX - STEP_PX;
              2'd2:    PacY <= PacY + STEP_PX;
              default: PacX <= (PacX == MAX_X) ? 10'd0 : PacX + STEP_PX;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pacman_motion.md
Name: pacman_motion

Overview:
- Per-frame Pac-Man position controller that sits directly upstream of the maze wall lookup.
- On each frame_clk rising edge it drives probe pixel coordinates into the wall lookup and reads back the combinational isWall result. It then decides turn, continue or stop, and updates PacX/PacY.
- Its outputs feed the sprite renderer and the dot/ghost collision logic.

Parameters:
- START_X, 208, reset pixel X of sprite top-left (tile column 13).
- START_Y, 320, reset pixel Y of sprite top-left (tile row 20).
- STEP, 1, pixels moved per frame; must be 1, 2, 4 or 8 (divides 16).
- MAX_X, 432, X of the rightmost tile (column 27); tunnel wrap target.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous active-high reset
- frame_clk  in  1  vsync-rate strobe, asynchronous to logic; edge-detected internally
- keycode  in  8  USB HID keycode: 0x1A=W up, 0x04=A left, 0x16=S down, 0x07=D right; anything else = no request
- isWall  in  1  combinational wall lookup result for (probe_x, probe_y)
- probe_x  out  10  pixel X presented to the wall lookup
- probe_y  out  10  pixel Y presented to the wall lookup
- PacX  out  10  sprite top-left X
- PacY  out  10  sprite top-left Y
- dir  out  2  current heading: 0=up, 1=left, 2=down, 3=right
- moving  out  1  1 while the last MOVE step advanced the sprite

Behaviour:
- Reset (async, any state): PacX=START_X, PacY=START_Y, dir=1 (left), req_dir=1, moving=0, FSM=IDLE, probe=(0,0), frame_clk edge register cleared.
- frame_clk: sampled through a 2-flop synchronizer plus an edge flop. frame_tick is a one-Clk pulse on the synchronized rising edge.
- req_dir register:
  - Updated on any Clk edge where keycode is one of the four valid codes.
  - Invalid or zero keycodes leave it unchanged; the latest request persists.
- Aligned means PacX[3:0]==0 and PacY[3:0]==0.
- Probe point for direction d (combinational from state, PacX/PacY and the direction under test, 10-bit wrap arithmetic):
  - up: (PacX, PacY-1)
  - left: (PacX-1, PacY)
  - down: (PacX, PacY+16)
  - right: (PacX+16, PacY)
  - PacX-1 with PacX=0 yields 1023, which the lookup treats as open; this is intended for the tunnel.
- FSM states IDLE, PROBE_REQ, PROBE_CUR, MOVE:
  - IDLE: on frame_tick, go to PROBE_REQ if aligned and req_dir!=dir; otherwise go to PROBE_CUR.
  - PROBE_REQ: probe = point(req_dir). Sample isWall at the end of the cycle.
    - If 0: dir<=req_dir, next state MOVE with go=1.
    - If 1: next state PROBE_CUR.
  - PROBE_CUR: probe = point(dir). go<=~isWall. Next state MOVE.
  - MOVE (one cycle), then IDLE:
    - If go, advance STEP pixels along dir and set moving=1.
    - Else hold position and set moving=0.
- Perpendicular axis is always tile-aligned. Reversal (req_dir opposite dir) is allowed only when aligned, like any turn.
- Tunnel wrap, applied in MOVE:
  - Heading left with PacX=0: PacX<=MAX_X.
  - Heading right with PacX=MAX_X: PacX<=0.
  - No vertical wrap.
- Latency: PacX/PacY update 5 or 6 Clk cycles after the frame_clk rising edge (synchronizer plus FSM). They are stable for the rest of the frame.
- frame_tick arriving while not in IDLE is dropped. This cannot occur at real frame rates.
- probe_x/probe_y equal (0,0) in IDLE and MOVE.

Test Plan:
- Reset mid-MOVE (assert Reset during MOVE after several frames of motion) -> outputs return immediately to (208,320), dir=1, moving=0. No update on the next frame_tick until the full probe sequence completes.
- After reset, no key, 176 frames -> PacX steps 208→32 (1 px/frame), PacY=320. Frame 177: moving=0, PacX stays 32 (tile column 1 of row 20 is wall).
- From reset, keycode=0x1A held -> first frame turns up (dir=0). PacY 320→304 over 16 frames. Next frame isWall=1 at (208,303): stop, moving=0.
- From reset, keycode=0x16 -> PacY 320→352 over 32 frames, then stops (row 23 column 13 is wall).
- Buffered turn: START=(16,240), moving right. Press 0x16 at PacX=21, then release the key -> keeps heading right until PacX=32 (aligned); probe (32,256); turn down only if isWall=0, else continue right with req_dir still pending.
- Tunnel: START_X=16, START_Y=240, no key -> PacX reaches 0 after 16 frames. Next frame PacX=432 with dir=1 retained; the following frame PacX=431.
